// File: rtl/matrix_entry_loader.sv
// Assembles staged keycodes into a DIM x DIM operand matrix, commits it to
// register A or B, and presents it to the matrix ALU with a valid/ready handshake.
module matrix_entry_loader #(
   parameter int WIDTH = 9,
   parameter int DIM   = 2
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [WIDTH-1:0]                               keycode,
   input  logic                                           store_dig,
   input  logic                                           enter,
   input  logic                                           write_en,
   input  logic                                           mat_sel,
   input  logic                                           abort,
   input  logic                                           out_ready,
   output logic [((DIM*DIM > 1) ? $clog2(DIM*DIM) : 1)-1:0] elem_idx,
   output logic                                           busy,
   output logic                                           mat_valid,
   output logic                                           which_mat,
   output logic [DIM*DIM*WIDTH-1:0]                       mat_a,
   output logic [DIM*DIM*WIDTH-1:0]                       mat_b,
   output logic                                           err_nostage
);

   localparam int N    = DIM * DIM;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      PRESENT
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] staging;
   logic             staged;
   logic             target;
   logic [WIDTH-1:0] work [N];
   logic [N*WIDTH-1:0] commit_vec;

   logic accept;
   logic wr;
   logic err;
   logic stage;
   logic last;
   logic commit;
   logic tgt;

   // Abort outranks both the element write and the staging capture.
   assign accept = (state != PRESENT);
   assign wr     = accept & enter & write_en & staged & ~abort;
   assign err    = accept & enter & write_en & ~staged & ~abort;
   assign stage  = accept & store_dig & ~abort;
   assign last   = (elem_idx == LAST_IDX);
   assign commit = wr & last;
   assign tgt    = (state == IDLE) ? mat_sel : target;
   assign busy   = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, e.g. the write sees the old staging value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (wr) begin
               state_next = last ? PRESENT : FILL;
            end
         end
         FILL: begin
            if (abort) begin
               state_next = IDLE;
            end else if (commit) begin
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (abort || out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The element being written on the commit edge comes from staging, not work.
   always_comb begin
      commit_vec = '0;
      for (int k = 0; k < N; k++) begin
         commit_vec[k*WIDTH +: WIDTH] = (IDXW'(k) == elem_idx) ? staging : work[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         elem_idx    <= '0;
         staging     <= '0;
         staged      <= 1'b0;
         target      <= 1'b0;
         mat_a       <= '0;
         mat_b       <= '0;
         mat_valid   <= 1'b0;
         which_mat   <= 1'b0;
         err_nostage <= 1'b0;
         // NOTE: the work array is small and must read as zero after reset and
         // abort, so it is built from resettable flops rather than a RAM.
         for (int k = 0; k < N; k++) begin
            work[k] <= '0;
         end
      end else begin
         err_nostage <= err;

         if (stage) begin
            staging <= keycode;
            staged  <= 1'b1;
         end else if (wr || (abort && accept)) begin
            staged <= 1'b0;
         end

         if (wr) begin
            work[elem_idx] <= staging;
            elem_idx       <= commit ? '0 : elem_idx + IDXW'(1);
            if (state == IDLE) begin
               target <= mat_sel;
            end
         end

         if (commit) begin
            if (tgt) begin
               mat_b <= commit_vec;
            end else begin
               mat_a <= commit_vec;
            end
            which_mat <= tgt;
            mat_valid <= 1'b1;
         end

         if (abort && state == FILL) begin
            elem_idx <= '0;
            for (int k = 0; k < N; k++) begin
               work[k] <= '0;
            end
         end

         if (state == PRESENT && (abort || out_ready)) begin
            mat_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_matrix_entry_loader.sv
// Scenario bench for matrix_entry_loader: a scoreboard queue holds each
// expected commit and a monitor compares it when mat_valid rises.
module tb_matrix_entry_loader;

   localparam int WIDTH = 9;
   localparam int DIM   = 2;
   localparam int N     = DIM * DIM;
   localparam int MW    = N * WIDTH;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] keycode = '0;
   logic             store_dig = 1'b0;
   logic             enter = 1'b0;
   logic             write_en = 1'b0;
   logic             mat_sel = 1'b0;
   logic             abort = 1'b0;
   logic             out_ready = 1'b0;
   logic [1:0]       elem_idx;
   logic             busy;
   logic             mat_valid;
   logic             which_mat;
   logic [MW-1:0]    mat_a;
   logic [MW-1:0]    mat_b;
   logic             err_nostage;

   typedef struct packed {
      logic          which;
      logic [MW-1:0] a;
      logic [MW-1:0] b;
   } commit_t;

   commit_t       sb_q[$];
   commit_t       exp_c;
   logic [MW-1:0] model_a = '0;
   logic [MW-1:0] model_b = '0;
   logic          prev_valid = 1'b0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   matrix_entry_loader #(.WIDTH(WIDTH), .DIM(DIM)) dut (
      .clk(clk),
      .reset(reset),
      .keycode(keycode),
      .store_dig(store_dig),
      .enter(enter),
      .write_en(write_en),
      .mat_sel(mat_sel),
      .abort(abort),
      .out_ready(out_ready),
      .elem_idx(elem_idx),
      .busy(busy),
      .mat_valid(mat_valid),
      .which_mat(which_mat),
      .mat_a(mat_a),
      .mat_b(mat_b),
      .err_nostage(err_nostage)
   );

   // Commit monitor: each rising mat_valid must match the oldest expected commit.
   always @(negedge clk) begin
      if (mat_valid === 1'b1 && prev_valid !== 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: mat_valid rose with which_mat=%0d, no commit expected", which_mat);
         end else begin
            exp_c = sb_q.pop_front();
            if (which_mat !== exp_c.which || mat_a !== exp_c.a || mat_b !== exp_c.b) begin
               errors++;
               $display("FAIL commit_data: got which=%0d a=%h b=%h, required which=%0d a=%h b=%h",
                        which_mat, mat_a, mat_b, exp_c.which, exp_c.a, exp_c.b);
            end
         end
      end
      prev_valid = mat_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [MW-1:0] pack4(input logic [WIDTH-1:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic stage_val(input logic [WIDTH-1:0] v);
      keycode   = v;
      store_dig = 1'b1;
      step();
      store_dig = 1'b0;
   endtask

   task automatic enter_val();
      enter    = 1'b1;
      write_en = 1'b1;
      step();
      enter    = 1'b0;
      write_en = 1'b0;
   endtask

   // mat_sel is inverted after the first element to show only the first write samples it.
   task automatic fill(input logic [MW-1:0] vals, input logic sel, input string tag);
      for (int k = 0; k < N; k++) begin
         stage_val(vals[k*WIDTH +: WIDTH]);
         mat_sel = (k == 0) ? sel : ~sel;
         if (k == N - 1) begin
            if (sel) model_b = vals;
            else     model_a = vals;
            sb_q.push_back('{which: sel, a: model_a, b: model_b});
         end
         enter_val();
         if (k < N - 1) begin
            checks++;
            if (elem_idx !== 2'(k + 1) || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s_idx: elem_idx=%0d busy=%0d, required %0d busy=1", tag, elem_idx, busy, k + 1);
            end
         end
      end
      mat_sel = 1'b0;
      checks++;
      if (mat_valid !== 1'b1 || elem_idx !== 2'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_latency: mat_valid=%0d elem_idx=%0d busy=%0d, required 1 0 1", tag, mat_valid, elem_idx, busy);
      end
   endtask

   task automatic accept(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (mat_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_accept: mat_valid=%0d busy=%0d, required 0 0", tag, mat_valid, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++;
      if (elem_idx !== 2'd0 || busy !== 1'b0 || mat_valid !== 1'b0 || which_mat !== 1'b0 ||
          mat_a !== '0 || mat_b !== '0 || err_nostage !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: idx=%0d busy=%0d valid=%0d which=%0d a=%h b=%h err=%0d, required all zero",
                  elem_idx, busy, mat_valid, which_mat, mat_a, mat_b, err_nostage);
      end
   endtask

   task automatic test_fill_a();
      fill(pack4(9'd1, 9'd2, 9'd3, 9'd4), 1'b0, "fill_a");
      checks++;
      if (mat_a !== {9'd4, 9'd3, 9'd2, 9'd1} || which_mat !== 1'b0) begin
         errors++;
         $display("FAIL fill_a_layout: mat_a=%h which=%0d, required %h which=0",
                  mat_a, which_mat, {9'd4, 9'd3, 9'd2, 9'd1});
      end
      accept("fill_a");
   endtask

   task automatic test_ab_independence();
      fill(pack4(9'd5, 9'd6, 9'd7, 9'd8), 1'b0, "ab_a");
      accept("ab_a");
      fill({N{9'h1FF}}, 1'b1, "ab_b");
      checks++;
      if (mat_b !== {N{9'h1FF}} || mat_a !== {9'd8, 9'd7, 9'd6, 9'd5} || which_mat !== 1'b1) begin
         errors++;
         $display("FAIL ab_independence: a=%h b=%h which=%0d, required a=%h b=%h which=1",
                  mat_a, mat_b, which_mat, {9'd8, 9'd7, 9'd6, 9'd5}, {N{9'h1FF}});
      end
      accept("ab_b");
   endtask

   task automatic test_nostage();
      enter_val();
      checks++;
      if (err_nostage !== 1'b1 || elem_idx !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL nostage_pulse: err=%0d idx=%0d busy=%0d, required 1 0 0", err_nostage, elem_idx, busy);
      end
      step();
      checks++;
      if (err_nostage !== 1'b0) begin
         errors++;
         $display("FAIL nostage_width: err=%0d one cycle later, required 0", err_nostage);
      end
      enter = 1'b1;
      step();
      enter = 1'b0;
      checks++;
      if (err_nostage !== 1'b0) begin
         errors++;
         $display("FAIL nostage_gated: err=%0d with write_en=0, required 0", err_nostage);
      end
      stage_val(9'd33);
      enter = 1'b1;
      step();
      enter = 1'b0;
      checks++;
      if (elem_idx !== 2'd0 || busy !== 1'b0 || err_nostage !== 1'b0) begin
         errors++;
         $display("FAIL enter_no_wen: idx=%0d busy=%0d err=%0d, required 0 0 0", elem_idx, busy, err_nostage);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      enter_val();
      checks++;
      if (err_nostage !== 1'b1 || elem_idx !== 2'd0) begin
         errors++;
         $display("FAIL idle_abort_unstage: err=%0d idx=%0d, required 1 0", err_nostage, elem_idx);
      end
      step();
   endtask

   task automatic test_abort();
      mat_sel = 1'b1;
      stage_val(9'd10);
      enter_val();
      mat_sel = 1'b0;
      stage_val(9'd11);
      enter_val();
      checks++;
      if (elem_idx !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_prefill: idx=%0d busy=%0d, required 2 1", elem_idx, busy);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (elem_idx !== 2'd0 || busy !== 1'b0 || mat_b !== model_b) begin
         errors++;
         $display("FAIL abort_fill: idx=%0d busy=%0d b=%h, required 0 0 %h", elem_idx, busy, mat_b, model_b);
      end
      fill(pack4(9'd21, 9'd22, 9'd23, 9'd24), 1'b0, "abort_refill");
      checks++;
      if (which_mat !== 1'b0 || mat_b !== model_b) begin
         errors++;
         $display("FAIL abort_refill_target: which=%0d b=%h, required 0 %h", which_mat, mat_b, model_b);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (mat_valid !== 1'b0 || busy !== 1'b0 || mat_a !== model_a) begin
         errors++;
         $display("FAIL abort_present: valid=%0d busy=%0d a=%h, required 0 0 %h", mat_valid, busy, mat_a, model_a);
      end
   endtask

   task automatic test_backpressure();
      fill(pack4(9'd40, 9'd41, 9'd42, 9'd43), 1'b0, "bp");
      for (int i = 0; i < 10; i++) begin
         keycode   = 9'(100 + i);
         store_dig = i[0];
         enter     = ~i[0];
         write_en  = 1'b1;
         step();
         checks++;
         if (mat_valid !== 1'b1 || mat_a !== model_a || elem_idx !== 2'd0 || err_nostage !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: valid=%0d a=%h idx=%0d err=%0d, required 1 %h 0 0",
                     i, mat_valid, mat_a, elem_idx, err_nostage, model_a);
         end
      end
      store_dig = 1'b0;
      enter     = 1'b0;
      write_en  = 1'b0;
      accept("bp");
      enter_val();
      checks++;
      if (err_nostage !== 1'b1 || elem_idx !== 2'd0) begin
         errors++;
         $display("FAIL bp_store_ignored: err=%0d idx=%0d, required 1 0", err_nostage, elem_idx);
      end
      step();
   endtask

   task automatic test_simultaneous();
      stage_val(9'd3);
      keycode   = 9'd7;
      store_dig = 1'b1;
      enter     = 1'b1;
      write_en  = 1'b1;
      mat_sel   = 1'b1;
      step();
      store_dig = 1'b0;
      enter     = 1'b0;
      write_en  = 1'b0;
      mat_sel   = 1'b0;
      checks++;
      if (elem_idx !== 2'd1) begin
         errors++;
         $display("FAIL simul_write: idx=%0d, required 1", elem_idx);
      end
      enter_val();
      checks++;
      if (elem_idx !== 2'd2 || err_nostage !== 1'b0) begin
         errors++;
         $display("FAIL simul_still_staged: idx=%0d err=%0d, required 2 0", elem_idx, err_nostage);
      end
      model_b = pack4(9'd3, 9'd7, 9'd11, 9'd12);
      sb_q.push_back('{which: 1'b1, a: model_a, b: model_b});
      stage_val(9'd11);
      enter_val();
      stage_val(9'd12);
      enter_val();
      checks++;
      if (mat_valid !== 1'b1 || mat_b !== {9'd12, 9'd11, 9'd7, 9'd3} || which_mat !== 1'b1) begin
         errors++;
         $display("FAIL simul_commit: valid=%0d b=%h which=%0d, required 1 %h 1",
                  mat_valid, mat_b, which_mat, {9'd12, 9'd11, 9'd7, 9'd3});
      end
      accept("simul");
   endtask

   task automatic test_reset_fill();
      stage_val(9'd50);
      enter_val();
      stage_val(9'd51);
      enter_val();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_a = '0;
      model_b = '0;
      checks++;
      if (elem_idx !== 2'd0 || busy !== 1'b0 || mat_valid !== 1'b0 || which_mat !== 1'b0 ||
          mat_a !== '0 || mat_b !== '0 || err_nostage !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_fill: idx=%0d busy=%0d valid=%0d which=%0d a=%h b=%h err=%0d, required all zero",
                  elem_idx, busy, mat_valid, which_mat, mat_a, mat_b, err_nostage);
      end
      fill(pack4(9'd1, 9'd1, 9'd2, 9'd2), 1'b1, "post_reset");
      accept("post_reset");
   endtask

   initial begin
      test_reset();
      test_fill_a();
      test_ab_independence();
      test_nostage();
      test_abort();
      test_backpressure();
      test_simultaneous();
      test_reset_fill();
      step();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d commits never observed, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_entry_loader.md
Name: matrix_entry_loader

Overview:
Sits directly downstream of the binary key encoder. It takes the 9-bit keycode and the store_dig/enter/write_en pulses and assembles the entered numbers, element by element, into a DIM x DIM operand matrix. When the matrix is complete it commits it to operand register A or B and presents it to the matrix ALU through a valid/ready handshake.

Parameters:
WIDTH, 9, bit width of one matrix element; equals the keycode width.
DIM, 2, matrix dimension; the matrix holds DIM*DIM elements.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
keycode  input  WIDTH  assembled number from the key encoder.
store_dig  input  1  one-cycle pulse: keycode is final; capture it into staging.
enter  input  1  one-cycle pulse: commit the staged value as the next element.
write_en  input  1  qualifies enter; enter is ignored when write_en=0.
mat_sel  input  1  target register, 0=A, 1=B; sampled on the first element write.
abort  input  1  discard a partial matrix.
out_ready  input  1  ALU accepts the presented matrix.
elem_idx  output  clog2(DIM*DIM)  index of the next element to be written.
busy  output  1  high in FILL and PRESENT.
mat_valid  output  1  committed matrix is presented.
which_mat  output  1  register committed last, 0=A, 1=B.
mat_a  output  DIM*DIM*WIDTH  operand A. Element k occupies bits [k*WIDTH +: WIDTH]; row-major order.
mat_b  output  DIM*DIM*WIDTH  operand B, same layout as mat_a.
err_nostage  output  1  one-cycle pulse when enter&write_en arrives with nothing staged.

Behaviour:
- Reset (synchronous, takes priority over every other input):
  - state=IDLE; elem_idx=0.
  - staging=0, staged=0.
  - work, mat_a and mat_b all zero.
  - mat_valid=0, which_mat=0, busy=0, err_nostage=0.
- Staging:
  - On store_dig in IDLE or FILL: staging<=keycode, staged<=1.
  - store_dig in PRESENT is ignored.
- Element write, wr = enter & write_en & staged, in IDLE or FILL:
  - work[elem_idx]<=staging; elem_idx++; staged<=0.
  - In IDLE, the same edge latches target<=mat_sel and moves to FILL.
- enter & write_en with staged=0 (IDLE or FILL): err_nostage pulses for 1 cycle; nothing else changes.
- store_dig and wr in the same cycle:
  - The write uses the old staging value.
  - staging then takes keycode and staged stays 1.
- FSM:
  - IDLE -> FILL on the first wr.
  - FILL -> PRESENT on the wr with elem_idx==DIM*DIM-1. On that same edge:
    - the complete work array, including the final element, is copied to mat_a if target=0, or to mat_b if target=1;
    - which_mat<=target; mat_valid<=1; elem_idx<=0.
  - PRESENT -> IDLE on out_ready; mat_valid drops the next cycle.
  - out_ready is don't-care outside PRESENT.
- Latency: the final-element enter at edge N gives mat_valid=1 and an updated mat_x visible after edge N (one clock).
- Input handling in PRESENT: enter and store_dig are ignored. With DIM=2, a single-element matrix is not possible.
- abort:
  - In FILL: go to IDLE; elem_idx=0; staged=0; work cleared. mat_a and mat_b are unchanged.
  - In PRESENT: mat_valid<=0 and go to IDLE; mat_a and mat_b keep their committed values.
  - In IDLE: clears staged only.
  - abort takes priority over a simultaneous wr or out_ready.
- Committed registers:
  - A register holds its value until the next commit to the same target.
  - Committing to B never disturbs A, and vice versa.
- elem_idx counts 0..DIM*DIM-1 and then wraps to 0 only through the commit; it never exceeds DIM*DIM-1.
- Arithmetic: none; elements are stored verbatim with no sign handling.

Test Plan:
Fill A (DIM=2, WIDTH=9): stage+enter 1,2,3,4 with mat_sel=0 -> mat_a=={4,3,2,1} (element 3 in the MSBs), mat_valid=1 one cycle after the 4th enter, which_mat=0, elem_idx=0; out_ready=1 -> mat_valid=0 and state IDLE.
A/B independence: fill A with 5,6,7,8, accept it, then fill B with 9'h1FF x4 and mat_sel=1 -> mat_b all 1FF, mat_a still {8,7,6,5}, which_mat=1.
Enter without stage: enter=1, write_en=1, with no prior store_dig -> err_nostage high 1 cycle, elem_idx stays 0, busy=0; enter with write_en=0 -> no effect and no error.
Abort mid-fill: write 2 elements into B, then abort -> elem_idx=0, busy=0, mat_b unchanged; the next 4 entries with mat_sel=0 land in A.
Backpressure: hold out_ready=0 for 10 cycles after completion and pulse store_dig/enter meanwhile -> mat_valid held, mat_a stable, elem_idx=0; release -> IDLE.
Simultaneous and reset: store_dig(k=7) and enter in the same cycle with staging=3 -> element written is 3 and staged stays 1; assert reset during FILL -> all outputs zero on the next edge.
